// File: rtl/counter_nb_pkg.sv
// rtl/counter_nb_pkg.sv - shared types and limits for the counter_nb block
//
// Purpose : direction and mode enums plus the prescaler range limit used by
//           counter_nb and counter_nb_prescale.
// Ports   : none (package).
package counter_nb_pkg;

    typedef enum logic {DIR_DOWN = 1'b0, DIR_UP = 1'b1} dir_e;

    typedef enum logic {MODE_WRAP = 1'b0, MODE_SAT = 1'b1} cnt_mode_e;

    localparam int PRESCALE_MAX = 65535;

endpackage

// File: rtl/counter_nb_prescale.sv
// rtl/counter_nb_prescale.sv - optional en-cycle prescaler for counter_nb
//
// Purpose : divides qualified en cycles by PRESCALE. Built only when the
//           macro COUNTER_NB_PRESCALE_EN is defined; otherwise tick = en.
// Ports   : clk     in  1  system clock, rising edge
//           reset   in  1  synchronous active-high reset
//           en      in  1  count enable from the parent
//           restart in  1  zero the prescaler (parent clr or load)
//           tick    out 1  one count step is due this cycle
module counter_nb_prescale
    import counter_nb_pkg::*;
#(
    parameter int unsigned PRESCALE = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic restart,
    output logic tick
);

    if (PRESCALE < 1 || PRESCALE > PRESCALE_MAX) begin : g_bad_prescale
        $error("counter_nb_prescale: PRESCALE out of range 1..65535");
    end

`ifdef COUNTER_NB_PRESCALE_EN
    // PRESCALE=1 still needs a 1-bit register; it stays at 0 so every en ticks.
    localparam int unsigned     PW   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0]   LAST = PW'(PRESCALE - 1);
    localparam logic [PW-1:0]   ONE  = PW'(1);

    logic [PW-1:0] pre_q;

    assign tick = en && (pre_q == LAST);

    always_ff @(posedge clk) begin
        if (reset || restart) begin
            pre_q <= '0;
        end else if (en) begin
            pre_q <= tick ? '0 : pre_q + ONE;
        end
    end
`else
    assign tick = en;

    logic unused_ok;
    assign unused_ok = &{1'b0, clk, reset, restart};
`endif

endmodule

// File: rtl/counter_nb.sv
// rtl/counter_nb.sv - parametrised up/down wrap/saturate counter with flags
//
// Purpose : WIDTH-bit counter bounded to 0..MAX_VAL with clear, clamped
//           parallel load, terminal/zero flags, registered wrap pulse and a
//           sticky saturation flag. Optional prescaler via the macro
//           COUNTER_NB_PRESCALE_EN.
// Ports   : clk      in  1      system clock, rising edge
//           reset    in  1      synchronous active-high reset
//           en       in  1      count enable
//           clr      in  1      synchronous clear
//           load     in  1      parallel load strobe
//           load_val in  WIDTH  load value (clamped to MAX_VAL)
//           dir      in  1      1 = up, 0 = down
//           count    out WIDTH  registered count
//           at_max   out 1      count == MAX_VAL
//           at_zero  out 1      count == 0
//           wrap     out 1      one-cycle pulse after a boundary event
//           sat      out 1      sticky blocked-step flag (SATURATE=1 only)
module counter_nb
    import counter_nb_pkg::*;
#(
    parameter int unsigned     WIDTH    = 6,
    parameter longint unsigned MAX_VAL  = (64'd1 << WIDTH) - 64'd1,
    parameter bit              SATURATE = 1'b0,
    parameter int unsigned     PRESCALE = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             dir,
    output logic [WIDTH-1:0] count,
    output logic             at_max,
    output logic             at_zero,
    output logic             wrap,
    output logic             sat
);

    if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
        $error("counter_nb: WIDTH out of range 1..32");
    end

    if (MAX_VAL < 64'd1 || MAX_VAL > ((64'd1 << WIDTH) - 64'd1)) begin : g_bad_max
        $error("counter_nb: MAX_VAL out of range 1..2**WIDTH-1");
    end

    localparam cnt_mode_e        MODE  = SATURATE ? MODE_SAT : MODE_WRAP;
    localparam logic [WIDTH:0]   MAX_X = (WIDTH + 1)'(MAX_VAL);
    localparam logic [WIDTH:0]   ONE_X = (WIDTH + 1)'(1);

    logic [WIDTH-1:0] count_q;
    logic             wrap_q;
    logic             sat_q;
    logic             step;
    dir_e             step_dir;

    // One extra bit so MAX_VAL = 2**WIDTH-1 cannot overflow into a false "below max".
    logic [WIDTH:0]   up_x;
    logic [WIDTH:0]   dn_x;
    logic [WIDTH:0]   load_x;
    logic             up_over;
    logic             dn_under;
    logic [WIDTH-1:0] load_clamped;

    counter_nb_prescale #(
        .PRESCALE (PRESCALE)
    ) u_prescale (
        .clk     (clk),
        .reset   (reset),
        .en      (en),
        .restart (clr | load),
        .tick    (step)
    );

    assign step_dir     = dir_e'(dir);
    assign up_x         = {1'b0, count_q} + ONE_X;
    assign dn_x         = {1'b0, count_q} - ONE_X;
    assign up_over      = (up_x > MAX_X);
    assign dn_under     = dn_x[WIDTH];
    assign load_x       = {1'b0, load_val};
    assign load_clamped = (load_x > MAX_X) ? MAX_X[WIDTH-1:0] : load_val;

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
            wrap_q  <= 1'b0;
            sat_q   <= 1'b0;
        end else if (clr) begin
            count_q <= '0;
            wrap_q  <= 1'b0;
            sat_q   <= 1'b0;
        end else if (load) begin
            count_q <= load_clamped;
            wrap_q  <= 1'b0;
        end else begin
            wrap_q <= 1'b0;
            if (step) begin
                if (step_dir == DIR_UP) begin
                    if (!up_over) begin
                        count_q <= up_x[WIDTH-1:0];
                    end else if (MODE == MODE_WRAP) begin
                        count_q <= '0;
                        wrap_q  <= 1'b1;
                    end else begin
                        // Pulse only on the first blocked step; sat records it.
                        wrap_q <= !sat_q;
                        sat_q  <= 1'b1;
                    end
                end else begin
                    if (!dn_under) begin
                        count_q <= dn_x[WIDTH-1:0];
                    end else if (MODE == MODE_WRAP) begin
                        count_q <= MAX_X[WIDTH-1:0];
                        wrap_q  <= 1'b1;
                    end else begin
                        wrap_q <= !sat_q;
                        sat_q  <= 1'b1;
                    end
                end
            end
        end
    end

    assign count   = count_q;
    assign at_max  = ({1'b0, count_q} == MAX_X);
    assign at_zero = (count_q == '0);
    assign wrap    = wrap_q;
    assign sat     = sat_q;

endmodule

// File: tb/tb_counter_nb.sv
// tb/tb_counter_nb.sv - self-checking bench for counter_nb
module tb_counter_nb;

`ifdef COUNTER_NB_PRESCALE_EN
    localparam int P = 3;
`else
    localparam int P = 1;
`endif

    logic       clk = 1'b0;
    logic       reset, en, clr, load, dir;
    logic [5:0] lv6;
    logic [3:0] lv4;

    logic [5:0] cnt_a;
    logic [3:0] cnt_b, cnt_c;
    logic       max_a, max_b, max_c;
    logic       zero_a, zero_b, zero_c;
    logic       wrap_a, wrap_b, wrap_c;
    logic       sat_a, sat_b, sat_c;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    // Model state per instance: a = 6-bit wrap, b = 4-bit/9 wrap, c = 4-bit/9 saturate.
    int mc[3];
    int mw[3];
    int ms[3];
    int mp[3];
    int mx[3] = '{63, 9, 9};
    int sm[3] = '{0, 0, 1};

    always #5 clk = ~clk;

    counter_nb #(.WIDTH(6), .MAX_VAL(63), .SATURATE(1'b0), .PRESCALE(3)) u_a (
        .clk(clk), .reset(reset), .en(en), .clr(clr), .load(load), .load_val(lv6),
        .dir(dir), .count(cnt_a), .at_max(max_a), .at_zero(zero_a), .wrap(wrap_a), .sat(sat_a)
    );

    counter_nb #(.WIDTH(4), .MAX_VAL(9), .SATURATE(1'b0), .PRESCALE(3)) u_b (
        .clk(clk), .reset(reset), .en(en), .clr(clr), .load(load), .load_val(lv4),
        .dir(dir), .count(cnt_b), .at_max(max_b), .at_zero(zero_b), .wrap(wrap_b), .sat(sat_b)
    );

    counter_nb #(.WIDTH(4), .MAX_VAL(9), .SATURATE(1'b1), .PRESCALE(3)) u_c (
        .clk(clk), .reset(reset), .en(en), .clr(clr), .load(load), .load_val(lv4),
        .dir(dir), .count(cnt_c), .at_max(max_c), .at_zero(zero_c), .wrap(wrap_c), .sat(sat_c)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s cyc=%0d observed=%0d expected=%0d", tag, cyc, obs, exp);
        end
    endtask

    // Reference: the count lives on the ring 0..max; a step that would leave it
    // is a boundary event (wrap around the ring, or hold when saturating).
    task automatic model_edge();
        for (int i = 0; i < 3; i++) begin
            int lv;
            int nxt;
            lv = (i == 0) ? int'(lv6) : int'(lv4);
            if (reset || clr) begin
                mc[i] = 0; mw[i] = 0; ms[i] = 0; mp[i] = 0;
            end else if (load) begin
                mc[i] = (lv > mx[i]) ? mx[i] : lv;
                mw[i] = 0; mp[i] = 0;
            end else begin
                mw[i] = 0;
                if (en) begin
                    mp[i] = mp[i] + 1;
                    if (mp[i] == P) begin
                        mp[i] = 0;
                        nxt = dir ? mc[i] + 1 : mc[i] - 1;
                        if (nxt >= 0 && nxt <= mx[i]) begin
                            mc[i] = nxt;
                        end else if (sm[i] == 0) begin
                            mc[i] = (nxt + mx[i] + 1) % (mx[i] + 1);
                            mw[i] = 1;
                        end else begin
                            mw[i] = (ms[i] == 0) ? 1 : 0;
                            ms[i] = 1;
                        end
                    end
                end
            end
        end
    endtask

    task automatic check_all();
        int oc[3];
        int om[3];
        int oz[3];
        int ow[3];
        int os[3];
        oc = '{int'(cnt_a), int'(cnt_b), int'(cnt_c)};
        om = '{int'(max_a), int'(max_b), int'(max_c)};
        oz = '{int'(zero_a), int'(zero_b), int'(zero_c)};
        ow = '{int'(wrap_a), int'(wrap_b), int'(wrap_c)};
        os = '{int'(sat_a), int'(sat_b), int'(sat_c)};
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("count[%0d]", i), oc[i], mc[i]);
            chk($sformatf("at_max[%0d]", i), om[i], (mc[i] == mx[i]) ? 1 : 0);
            chk($sformatf("at_zero[%0d]", i), oz[i], (mc[i] == 0) ? 1 : 0);
            chk($sformatf("wrap[%0d]", i), ow[i], mw[i]);
            chk($sformatf("sat[%0d]", i), os[i], ms[i]);
        end
    endtask

    task automatic step_clk();
        model_edge();
        @(posedge clk);
        #1;
        cyc++;
        check_all();
    endtask

    task automatic drive(input logic r, input logic e, input logic c, input logic l,
                         input logic d, input int v);
        reset = r; en = e; clr = c; load = l; dir = d;
        lv6 = 6'(v); lv4 = 4'(v);
    endtask

    initial begin
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 0);
        step_clk();
        step_clk();

        // Up count through the full 6-bit range and wrap.
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 0);
        for (int k = 0; k < 64 * P; k++) step_clk();
        chk("a_wrapped_to_zero", int'(cnt_a), 0);

        // Down from reset: 9, 8, 7 on the MAX_VAL=9 counters.
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        step_clk();
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0);
        for (int k = 0; k < 3 * P; k++) step_clk();
        chk("b_down_to_7", int'(cnt_b), 7);

        // Saturate: load 7 then five up steps.
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 7);
        step_clk();
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 0);
        for (int k = 0; k < 5 * P; k++) step_clk();
        chk("c_held_at_9", int'(cnt_c), 9);
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 0);
        step_clk();

        // Priority: clamped load beats en, clr beats load, reset beats all.
        drive(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 12);
        step_clk();
        chk("c_load_clamp", int'(cnt_c), 9);
        drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 12);
        step_clk();
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 5);
        step_clk();
        drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 63);
        step_clk();

        // Reset mid-run at count 5 with en held high.
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 0);
        for (int k = 0; k < 5 * P; k++) step_clk();
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 0);
        step_clk();
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 0);
        for (int k = 0; k < P; k++) step_clk();
        chk("a_after_reset_run", int'(cnt_a), 1);

        // Prescaler phase handling: 9 en, 2 idle, partial, load mid-phase.
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 0);
        step_clk();
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 0);
        for (int k = 0; k < 9; k++) step_clk();
        chk("a_after_nine_en", int'(cnt_a), 9 / P);
        step_clk();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 0);
        step_clk();
        step_clk();
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 0);
        step_clk();
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2);
        step_clk();
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 0);
        for (int k = 0; k < 4; k++) step_clk();

        // Randomized traffic.
        for (int k = 0; k < 600; k++) begin
            drive(($urandom_range(0, 99) < 2) ? 1'b1 : 1'b0,
                  ($urandom_range(0, 99) < 75) ? 1'b1 : 1'b0,
                  ($urandom_range(0, 99) < 3) ? 1'b1 : 1'b0,
                  ($urandom_range(0, 99) < 5) ? 1'b1 : 1'b0,
                  ($urandom_range(0, 99) < 55) ? 1'b1 : 1'b0,
                  int'($urandom_range(0, 63)));
            step_clk();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
